// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_pkg
// Brief    : Shared types and constants for the write-back port arbiter.
// Revision : 1.0
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int c_ADDR_W = 5;
    localparam int c_DATA_W = 32;

    typedef logic [c_ADDR_W-1:0] gr_t;
    typedef logic [c_DATA_W-1:0] dtype_t;

    typedef struct packed {
        logic   valid;
        gr_t    rd;
        dtype_t data;
    } wb_req_t;

    localparam int c_WB_SRC_ALU = 0;
    localparam int c_WB_SRC_LSU = 1;
    localparam int c_WB_SRC_MDU = 2;

    // Population count of up to eight request lines.
    function automatic logic [3:0] count_ones(input logic [7:0] vec);
        logic [3:0] w_sum;
        w_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum = w_sum + {3'b000, vec[i]};
        end
        return w_sum;
    endfunction

endpackage : wb_port_arbiter_pkg
`default_nettype wire

// File: rtl/wb_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_rr_pick
// Brief    : Combinational round-robin picker starting the scan at ptr.
// Revision : 1.0
// ============================================================================
module wb_port_arbiter_rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [IDX_W-1:0] w_idx;

    // Scan from the farthest offset back to ptr so the nearest hit wins last.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        w_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IDX_W'((int'(ptr) + k) % NREQ);
            if (eligible[w_idx]) begin
                winner = w_idx;
                any    = 1'b1;
            end
        end
    end

endmodule : wb_port_arbiter_rr_pick
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Round-robin arbiter sharing the register-file write port.
// Revision : 1.0
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*ADDR_W-1:0]    req_rd,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      wb_en,
    output logic [ADDR_W-1:0]         wb_rd,
    output logic [DATA_W-1:0]         wb_data,
    output logic [$clog2(NREQ)-1:0]   wb_src,
    output logic [CNT_W-1:0]          contention_cnt
);

    localparam int c_IDX_W = $clog2(NREQ);

    logic [ADDR_W-1:0]  w_rd   [NREQ];
    logic [DATA_W-1:0]  w_data [NREQ];
    logic [NREQ-1:0]    w_eligible;
    logic [NREQ-1:0]    w_zero;
    logic [NREQ-1:0]    w_win_onehot;
    logic [c_IDX_W-1:0] w_winner;
    logic               w_any;
    logic               w_grant;
    logic               w_contend;
    logic [c_IDX_W-1:0] w_ptr_next;

    logic [c_IDX_W-1:0] r_ptr;
    logic               r_wb_en;
    logic [ADDR_W-1:0]  r_wb_rd;
    logic [DATA_W-1:0]  r_wb_data;
    logic [c_IDX_W-1:0] r_wb_src;
    logic [CNT_W-1:0]   r_cnt;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign w_rd[gi]       = req_rd[gi*ADDR_W +: ADDR_W];
        assign w_data[gi]     = req_data[gi*DATA_W +: DATA_W];
        assign w_eligible[gi] = req_valid[gi] && (w_rd[gi] != '0);
        assign w_zero[gi]     = req_valid[gi] && (w_rd[gi] == '0);
    end

    wb_port_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (c_IDX_W)
    ) u_rr_pick (
        .eligible (w_eligible),
        .ptr      (r_ptr),
        .winner   (w_winner),
        .any      (w_any)
    );

    assign w_grant   = w_any && !flush;
    assign w_contend = !flush && (count_ones(8'(w_eligible)) >= 4'd2);

    // r0 writes are sunk alongside the winner; flush blocks everything.
    always_comb begin
        w_win_onehot = '0;
        if (w_grant) begin
            w_win_onehot[w_winner] = 1'b1;
        end
        req_ready = w_win_onehot | (w_zero & {NREQ{!flush}});
    end

    always_comb begin
        w_ptr_next = r_ptr;
        if (flush) begin
            w_ptr_next = '0;
        end else if (w_grant) begin
            w_ptr_next = (w_winner == c_IDX_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_wb_src  <= '0;
            r_cnt     <= '0;
        end else begin
            r_ptr   <= w_ptr_next;
            r_wb_en <= w_grant;
            if (w_grant) begin
                r_wb_rd   <= w_rd[w_winner];
                r_wb_data <= w_data[w_winner];
                r_wb_src  <= w_winner;
            end
            if (w_contend && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign wb_en          = r_wb_en;
    assign wb_rd          = r_wb_rd;
    assign wb_data        = r_wb_data;
    assign wb_src         = r_wb_src;
    assign contention_cnt = r_cnt;

endmodule : wb_port_arbiter
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Brief    : Self-checking bench for wb_port_arbiter (NREQ=3, CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_wb_port_arbiter;

    localparam int c_NREQ   = 3;
    localparam int c_ADDR_W = 5;
    localparam int c_DATA_W = 32;
    localparam int c_CNT_W  = 4;

    logic         clk;
    logic         reset;
    logic         flush;
    logic [2:0]   req_valid;
    logic [14:0]  req_rd;
    logic [95:0]  req_data;
    logic [2:0]   req_ready;
    logic         wb_en;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic [1:0]   wb_src;
    logic [3:0]   contention_cnt;

    wb_port_arbiter #(
        .NREQ   (c_NREQ),
        .ADDR_W (c_ADDR_W),
        .DATA_W (c_DATA_W),
        .CNT_W  (c_CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_rd         (req_rd),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_src         (wb_src),
        .contention_cnt (contention_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       flush;
        logic [2:0] valid;
        logic [4:0] rd0;
        logic [4:0] rd1;
        logic [4:0] rd2;
        logic [2:0] exp_ready;
        int         exp_win;
    } vec_t;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  src;
        logic [3:0]  cnt;
    } sb_t;

    vec_t vecs[15];
    sb_t  sb_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [1:0]  m_src;
    logic [3:0]  m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stable per-requester data; requester 0 writing r5 uses the reference value.
    function automatic logic [31:0] req_word(input int idx, input logic [4:0] rd);
        if (idx == 0 && rd == 5'd5) return 32'h0000_1234;
        return {8'hC0 + 8'(idx), 19'h0, rd};
    endfunction

    task automatic drive(input logic [2:0] valid, input logic [4:0] r0,
                         input logic [4:0] r1, input logic [4:0] r2);
        req_valid = valid;
        req_rd    = {r2, r1, r0};
        req_data  = {req_word(2, r2), req_word(1, r1), req_word(0, r0)};
    endtask

    task automatic check_wb(input int step);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty step %0d: got 0 entries expected 1", step);
            return;
        end
        e = sb_q.pop_front();
        chk($sformatf("wb_en[%0d]", step), 32'(wb_en), 32'(e.en));
        if (e.en) begin
            m_rd   = e.rd;
            m_data = e.data;
            m_src  = e.src;
        end
        chk($sformatf("wb_rd[%0d]", step), 32'(wb_rd), 32'(m_rd));
        chk($sformatf("wb_data[%0d]", step), wb_data, m_data);
        chk($sformatf("wb_src[%0d]", step), 32'(wb_src), 32'(m_src));
        chk($sformatf("cnt[%0d]", step), 32'(contention_cnt), 32'(e.cnt));
    endtask

    initial begin
        logic [4:0] rds [3];
        sb_t        e;
        int         n_elig;

        // flush valid  rd0    rd1    rd2    ready   win
        vecs[0]  = '{1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 3'b001, 0};
        vecs[1]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1};
        vecs[2]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 2};
        vecs[3]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 0};
        vecs[4]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1};
        vecs[5]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 2};
        vecs[6]  = '{1'b0, 3'b011, 5'd4, 5'd0, 5'd0, 3'b011, 0};
        vecs[7]  = '{1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 3'b000, -1};
        vecs[8]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 0};
        vecs[9]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, -1};
        vecs[10] = '{1'b0, 3'b110, 5'd0, 5'd0, 5'd7, 3'b110, 2};
        vecs[11] = '{1'b0, 3'b010, 5'd0, 5'd0, 5'd0, 3'b010, -1};
        vecs[12] = '{1'b0, 3'b100, 5'd0, 5'd0, 5'd9, 3'b100, 2};
        vecs[13] = '{1'b0, 3'b011, 5'd3, 5'd3, 5'd0, 3'b001, 0};
        vecs[14] = '{1'b0, 3'b011, 5'd3, 5'd3, 5'd0, 3'b010, 1};

        // Reset held with all requesters valid.
        reset = 1'b0;
        flush = 1'b0;
        drive(3'b111, 5'd1, 5'd2, 5'd3);
        repeat (2) @(negedge clk);
        chk("reset_wb_en", 32'(wb_en), 32'd0);
        chk("reset_wb_rd", 32'(wb_rd), 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_wb_src", 32'(wb_src), 32'd0);
        chk("reset_cnt", 32'(contention_cnt), 32'd0);

        drive(3'b000, 5'd0, 5'd0, 5'd0);
        reset  = 1'b1;
        m_rd   = '0;
        m_data = '0;
        m_src  = '0;
        m_cnt  = '0;

        // Table-driven sequence with scoreboarded write-port results.
        for (int s = 0; s < 15; s++) begin
            @(negedge clk);
            if (s > 0) check_wb(s - 1);
            flush = vecs[s].flush;
            drive(vecs[s].valid, vecs[s].rd0, vecs[s].rd1, vecs[s].rd2);
            #1;
            chk($sformatf("req_ready[%0d]", s), 32'(req_ready), 32'(vecs[s].exp_ready));
            rds[0] = vecs[s].rd0;
            rds[1] = vecs[s].rd1;
            rds[2] = vecs[s].rd2;
            n_elig = 0;
            for (int i = 0; i < 3; i++) begin
                if (vecs[s].valid[i] && rds[i] != 5'd0) n_elig++;
            end
            if (!vecs[s].flush && n_elig >= 2 && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            e.en   = (vecs[s].exp_win >= 0);
            e.rd   = e.en ? rds[vecs[s].exp_win] : 5'd0;
            e.data = e.en ? req_word(vecs[s].exp_win, rds[vecs[s].exp_win]) : 32'd0;
            e.src  = e.en ? 2'(vecs[s].exp_win) : 2'd0;
            e.cnt  = m_cnt;
            sb_q.push_back(e);
        end
        @(negedge clk);
        check_wb(14);
        flush = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0);

        // Saturation: two eligible requesters for 20 cycles.
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        drive(3'b011, 5'd1, 5'd2, 5'd0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk($sformatf("sat_cnt[%0d]", k), 32'(contention_cnt), (k > 15) ? 32'd15 : 32'(k));
        end
        drive(3'b000, 5'd0, 5'd0, 5'd0);

        // Asynchronous reset while a write is registered.
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(negedge clk);
        drive(3'b001, 5'd5, 5'd0, 5'd0);
        @(posedge clk);
        #2;
        chk("async_pre_wb_en", 32'(wb_en), 32'd1);
        drive(3'b000, 5'd0, 5'd0, 5'd0);
        reset = 1'b0;
        #1;
        chk("async_wb_en", 32'(wb_en), 32'd0);
        chk("async_wb_rd", 32'(wb_rd), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(3'b111, 5'd1, 5'd2, 5'd3);
        #1;
        chk("async_ptr_ready", 32'(req_ready), 32'b001);
        @(posedge clk);
        #1;
        chk("async_post_wb_en", 32'(wb_en), 32'd1);
        chk("async_post_wb_src", 32'(wb_src), 32'd0);
        drive(3'b000, 5'd0, 5'd0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_wb_port_arbiter
`default_nettype wire
